// File: rtl/des_pkg.sv
// DES S-box constants and lookup helper.
// Shared by the lane and bank modules.
package des_pkg;

  localparam int LANES_1 = 1;
  localparam int LANES_2 = 2;
  localparam int LANES_4 = 4;
  localparam int LANES_8 = 8;
  localparam int NBOX    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Box-major, then row-major: entry [box][row*16+col], col 0 leftmost.
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row is the outer bit pair, column the inner four.
  function automatic logic [3:0] sbox_lookup(
    input logic [2:0] idx,
    input logic [5:0] six
  );
    return SBOX[idx][{six[5], six[0], six[4:1]}];
  endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// One combinational S-box lane.
// Box index selects which of S1..S8 is applied.
module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0] box_idx,
  input  logic [5:0] six,
  output logic [3:0] nib
);

  assign nib = sbox_lookup(box_idx, six);

endmodule

// File: rtl/des_sbox_bank.sv
// DES S1..S8 substitution bank with valid/ready on both sides.
// LANES boxes are evaluated per cycle over 8/LANES cycles.
module des_sbox_bank
  import des_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int NCYC = NBOX / LANES;
  localparam int CW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  if (!(LANES == LANES_1 || LANES == LANES_2 ||
        LANES == LANES_4 || LANES == LANES_8)) begin : g_bad_lanes
    $error("des_sbox_bank: LANES must be 1, 2, 4 or 8");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [47:0]   data_q, data_d;
  logic [31:0]   res_q, res_d;
  logic          vld_q, vld_d;
  logic          accept;

  logic [2:0] box_idx [LANES];
  logic [5:0] six     [LANES];
  logic [3:0] nib     [LANES];

  // Pick this cycle's groups out of the captured block by counter.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      box_idx[l] = 3'((int'(cnt_q) * LANES) + l);
      six[l] = data_q[47 - 6 * int'(box_idx[l]) -: 6];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_sbox_lane u_lane (
      .box_idx (box_idx[l]),
      .six     (six[l]),
      .nib     (nib[l])
    );
  end

  assign in_ready = rst_n &&
                    ((state_q == ST_IDLE) ||
                     (state_q == ST_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_q;
  assign out_data  = res_q;

  // Next-state, counter, capture and result-merge logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    res_d   = res_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[31 - 4 * int'(box_idx[l]) -: 4] = nib[l];
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
          if (accept) begin
            data_d  = in_data;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_bank.sv
// Bench for des_sbox_bank at LANES = 1, 2, 4, 8.
// Scoreboard queue per instance, checked by an independent monitor.
module tb_des_sbox_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    int          acc;
  } exp_t;

  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] ref_model(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  g;
    int          row;
    int          col;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      g   = d[47 - 6 * k -: 6];
      row = int'({g[5], g[0]});
      col = int'(g[4:1]);
      r[31 - 4 * k -: 4] = 4'(sb[k][row * 16 + col]);
    end
    return r;
  endfunction

  task automatic check(
    input string       nm,
    input int          l,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lanes=%0d got=%h want=%h t=%0t",
               nm, l, act, exp, $time);
    end
  endtask

  localparam logic [47:0] V_CLASSIC = 48'h6117BA866527;
  localparam logic [31:0] R_CLASSIC = 32'h5C82B597;
  localparam logic [47:0] V_ZERO    = 48'h000000000000;
  localparam logic [31:0] R_ZERO    = 32'hEFA72C4D;
  localparam logic [47:0] V_ONES    = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] R_ONES    = 32'hD9CE3DCB;
  localparam int          NRND      = 300;

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int L  = 1 << gi;
    localparam int NC = 8 / L;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    bit          fin = 1'b0;
    exp_t        q[$];

    des_sbox_bank #(.LANES(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

    // mode: 0 keep out_ready, 1 force high, 2 random
    task automatic set_ordy(input int mode);
      if (mode == 1) out_ready = 1'b1;
      else if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick(input int mode);
      @(negedge clk);
      in_valid = 1'b0;
      set_ordy(mode);
      #1;
    endtask

    task automatic send(
      input logic [47:0] d,
      input logic [31:0] e,
      input int          mode
    );
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        set_ordy(mode);
        #1;
        if (in_ready) begin
          q.push_back('{e, cyc + 1});
          ok = 1'b1;
        end
      end
      if (!ok) check("accept_timeout", L, 64'(ok), 64'(1));
    endtask

    task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if (q.size() == 0 && !out_valid && in_ready) break;
        tick(1);
      end
    endtask

    initial begin
      logic [47:0] d;
      int          c0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst_in_ready", L, 64'(in_ready), 64'(0));
      check("rst_out_valid", L, 64'(out_valid), 64'(0));
      check("rst_out_data", L, 64'(out_data), 64'(0));
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("idle_in_ready", L, 64'(in_ready), 64'(1));

      send(V_CLASSIC, R_CLASSIC, 1);
      for (int i = 0; i < NC; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '1;
        #1;
        check("busy_in_ready", L, 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      tick(1);
      send(V_ZERO, R_ZERO, 1);
      send(V_ONES, R_ONES, 1);
      drain();

      out_ready = 1'b0;
      send(V_ZERO, R_ZERO, 0);
      for (int i = 0; i < 40 && !out_valid; i++) tick(0);
      check("bp_valid", L, 64'(out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = V_CLASSIC;
        #1;
        check("bp_hold_valid", L, 64'(out_valid), 64'(1));
        check("bp_hold_data", L, 64'(out_data), 64'(R_ZERO));
        check("bp_in_ready", L, 64'(in_ready), 64'(0));
      end
      c0 = cyc;
      send(V_CLASSIC, R_CLASSIC, 1);
      check("b2b_accept_cycle", L, 64'(q[$].acc), 64'(c0 + 2));
      drain();

      send(V_CLASSIC, R_CLASSIC, 1);
      tick(1);
      repeat ((NC - 1 > 3) ? 3 : NC - 1) tick(1);
      rst_n = 1'b0;
      q.delete();
      tick(1);
      check("midrst_out_valid", L, 64'(out_valid), 64'(0));
      check("midrst_out_data", L, 64'(out_data), 64'(0));
      check("midrst_in_ready", L, 64'(in_ready), 64'(0));
      rst_n = 1'b1;
      #1;
      check("midrst_idle", L, 64'(in_ready), 64'(1));
      send(V_ONES, R_ONES, 1);
      drain();

      for (int n = 0; n < NRND; n++) begin
        d = {16'($urandom), $urandom};
        repeat ($urandom_range(0, 2)) tick(2);
        send(d, ref_model(d), 2);
      end
      drain();
      check("queue_empty", L, 64'(q.size()), 64'(0));
      fin = 1'b1;
    end

    initial begin
      bit          pv;
      bit          pr;
      bit          prst;
      logic [31:0] pd;
      exp_t        e;
      pv   = 1'b0;
      pr   = 1'b0;
      prst = 1'b0;
      pd   = '0;
      forever begin
        @(negedge clk);
        #2;
        if (pv && !pr && prst)
          check("stall_hold", L, 64'({out_valid, out_data}),
                64'({1'b1, pd}));
        if (out_valid && !pv) begin
          if (q.size() == 0)
            check("unexpected_out", L, 64'(q.size()), 64'(1));
          else
            check("latency", L, 64'(cyc), 64'(q[0].acc + NC));
        end
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          check("data", L, 64'(out_data), 64'(e.d));
        end
        pv   = out_valid;
        pr   = out_ready;
        prst = rst_n;
        pd   = out_data;
      end
    end
  end

  initial begin
    wait (g[0].fin && g[1].fin && g[2].fin && g[3].fin);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
